// File: rtl/axi_round_and_clip_multi.sv
// axi_round_and_clip_multi
// Multi-lane AXI-Stream round-and-clip stage. NUM_CHAN packed signed lanes are
// narrowed from WIDTH_IN to WIDTH_OUT bits through a two-stage pipeline
// (stage 1 rounds, stage 2 saturates) sharing one handshake.
// Optional feature: define ROUND_CLIP_SAT_COUNT_EN to build the clip_count
// saturation event counter; otherwise clip_count is tied to zero.
module axi_round_and_clip_multi #(
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int CLIP_BITS = 3,
    parameter int NUM_CHAN  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    round_mode,
    input  logic                          clear_count,
    input  logic [NUM_CHAN*WIDTH_IN-1:0]  i_tdata,
    input  logic                          i_tlast,
    input  logic                          i_tvalid,
    output logic                          i_tready,
    output logic [NUM_CHAN*WIDTH_OUT-1:0] o_tdata,
    output logic [NUM_CHAN-1:0]           o_tclip,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          o_tready,
    output logic [CNT_WIDTH-1:0]          clip_count
);

    localparam int DROP = WIDTH_IN - WIDTH_OUT - CLIP_BITS;
    // width of the value kept after rounding: WIDTH_OUT + CLIP_BITS + sign guard
    localparam int KW   = WIDTH_OUT + CLIP_BITS + 1;

    generate
        if (DROP < 1) begin : g_bad_drop
            $error("axi_round_and_clip_multi: WIDTH_IN - WIDTH_OUT - CLIP_BITS must be >= 1");
        end
    endgenerate

    localparam logic [WIDTH_IN:0] ONE     = {{WIDTH_IN{1'b0}}, 1'b1};
    localparam logic [WIDTH_IN:0] HALF    = ONE << (DROP - 1);
    localparam logic [WIDTH_IN:0] HALF_M1 = HALF - ONE;

    localparam logic [WIDTH_OUT-1:0] SAT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] SAT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    // pipeline state
    logic                         s1_valid;
    logic [NUM_CHAN*KW-1:0]       s1_data;
    logic                         s1_last;
    logic                         s2_valid;

    logic                         s1_ready;
    logic                         s2_ready;

    // combinational stage results
    logic [NUM_CHAN*KW-1:0]        s1_next;
    logic [NUM_CHAN*WIDTH_OUT-1:0] s2_next;
    logic [NUM_CHAN-1:0]           s2_clip;

    logic [WIDTH_IN-1:0]  lane;
    logic [WIDTH_IN:0]    rc;
    logic [WIDTH_IN:0]    sum;
    logic [KW-1:0]        kept;
    logic [KW-WIDTH_OUT:0] top;

    assign s2_ready = !s2_valid || o_tready;
    assign s1_ready = !s1_valid || s2_ready;
    assign i_tready = s1_ready;
    assign o_tvalid = s2_valid;

    // Stage-1 rounding: sign-extend, add the mode-dependent constant, drop LSBs.
    // round_mode is consumed here, so each beat carries the mode it was accepted with.
    always_comb begin
        s1_next = '0;
        lane    = '0;
        rc      = '0;
        sum     = '0;
        for (int unsigned k = 0; k < NUM_CHAN; k++) begin
            lane = i_tdata[k*WIDTH_IN +: WIDTH_IN];
            case (round_mode)
                2'd0:    rc = '0;
                2'd2:    rc = HALF_M1 + {{WIDTH_IN{1'b0}}, lane[DROP]};
                default: rc = HALF;
            endcase
            sum = {lane[WIDTH_IN-1], lane} + rc;
            s1_next[k*KW +: KW] = sum[WIDTH_IN:DROP];
        end
    end

    // Stage-2 clipping: pass if all bits above the output sign agree, else saturate.
    always_comb begin
        s2_next = '0;
        s2_clip = '0;
        kept    = '0;
        top     = '0;
        for (int unsigned k = 0; k < NUM_CHAN; k++) begin
            kept = s1_data[k*KW +: KW];
            top  = kept[KW-1:WIDTH_OUT-1];
            if ((&top) || !(|top)) begin
                s2_next[k*WIDTH_OUT +: WIDTH_OUT] = kept[WIDTH_OUT-1:0];
            end else begin
                s2_next[k*WIDTH_OUT +: WIDTH_OUT] = kept[KW-1] ? SAT_MIN : SAT_MAX;
                s2_clip[k] = 1'b1;
            end
        end
    end

    // Stage-1 register: loads whenever empty or stage 2 is taking its beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= i_tvalid;
            if (i_tvalid) begin
                s1_data <= s1_next;
                s1_last <= i_tlast;
            end
        end
    end

    // Stage-2 (output) register: holds its payload while stalled downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            o_tdata  <= '0;
            o_tclip  <= '0;
            o_tlast  <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_tdata <= s2_next;
                o_tclip <= s2_clip;
                o_tlast <= s1_last;
            end
        end
    end

`ifdef ROUND_CLIP_SAT_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating count of output transfers with any lane clipped; clear wins.
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            cnt_q <= '0;
        end else if (o_tvalid && o_tready && (|o_tclip) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign clip_count = cnt_q;
`else
    logic unused_clear;

    assign unused_clear = clear_count;
    assign clip_count   = '0;
`endif

endmodule

// File: tb/tb_axi_round_and_clip_multi.sv
// tb_axi_round_and_clip_multi
// Self-checking bench: directed cases plus a randomized stream scored against
// an arithmetic reference model. Counter checks follow ROUND_CLIP_SAT_COUNT_EN.
module tb_axi_round_and_clip_multi;

    localparam int WI   = 24;
    localparam int WO   = 16;
    localparam int CB   = 3;
    localparam int NC   = 2;
    localparam int CW   = 16;
    localparam int DROP = WI - WO - CB;
`ifdef ROUND_CLIP_SAT_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    localparam logic [NC*WI-1:0] CLIPD = {24'h800000, 24'h3FFFFF};

    logic                 clk;
    logic                 reset;
    logic [1:0]           round_mode;
    logic                 clear_count;
    logic [NC*WI-1:0]     i_tdata;
    logic                 i_tlast;
    logic                 i_tvalid;
    logic                 i_tready;
    logic [NC*WO-1:0]     o_tdata;
    logic [NC-1:0]        o_tclip;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready;
    logic [CW-1:0]        clip_count;

    axi_round_and_clip_multi #(
        .WIDTH_IN (WI),
        .WIDTH_OUT(WO),
        .CLIP_BITS(CB),
        .NUM_CHAN (NC),
        .CNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .round_mode (round_mode),
        .clear_count(clear_count),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tclip    (o_tclip),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .clip_count (clip_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [NC*WO-1:0] d;
        logic [NC-1:0]    c;
        logic             l;
    } beat_t;

    // Reference: integer floor division, then resolve the remainder per mode,
    // then clamp to the signed output range. Returns {clip, value}.
    function automatic logic [WO:0] model_lane(input logic [WI-1:0] x, input logic [1:0] m);
        longint v, q, r, y, h, hi, lo;
        logic [63:0] yb;
        v  = longint'($signed(x));
        q  = v >>> DROP;
        r  = v - (q <<< DROP);
        h  = longint'(1) <<< (DROP - 1);
        hi = (longint'(1) <<< (WO - 1)) - 1;
        lo = -(longint'(1) <<< (WO - 1));
        case (m)
            2'd0:    y = q;
            2'd2:    y = (r > h) ? q + 1 : ((r == h) ? q + (q & 1) : q);
            default: y = (r >= h) ? q + 1 : q;
        endcase
        if (y > hi) return {1'b1, 1'b0, {(WO-1){1'b1}}};
        if (y < lo) return {1'b1, 1'b1, {(WO-1){1'b0}}};
        yb = 64'(y);
        return {1'b0, yb[WO-1:0]};
    endfunction

    function automatic beat_t model(input logic [NC*WI-1:0] din, input logic [1:0] m, input logic last);
        beat_t b;
        logic [WO:0] r;
        b.d = '0;
        b.c = '0;
        b.l = last;
        for (int k = 0; k < NC; k++) begin
            r = model_lane(din[k*WI +: WI], m);
            b.d[k*WO +: WO] = r[WO-1:0];
            b.c[k] = r[WO];
        end
        return b;
    endfunction

    function automatic logic [WI-1:0] gen_lane();
        int v;
        logic [31:0] u;
        u = $urandom;
        case ($urandom_range(0, 3))
            0:       v = int'(u);
            1:       v = int'($urandom_range(0, 1 << 22)) - (1 << 21);
            2:       v = (int'($urandom_range(0, 4095)) - 2048) * 32 + 16;
            default: v = int'($urandom_range(0, 2047)) - 1024;
        endcase
        return v[WI-1:0];
    endfunction

    // Scoreboard monitor, sampled on the falling edge where everything is settled.
    beat_t         sb[$];
    logic [CW-1:0] exp_cnt;
    logic          stall_hold;
    beat_t         held;
    beat_t         got_b;
    beat_t         exp_b;

    initial begin
        exp_cnt    = '0;
        stall_hold = 1'b0;
        held       = '0;
    end

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_cnt    = '0;
            stall_hold = 1'b0;
        end else begin
            check("cnt_model", clip_count, exp_cnt);
            if (stall_hold) begin
                check("hold_valid", o_tvalid, 1);
                check("hold_data", o_tdata, held.d);
                check("hold_clip", o_tclip, held.c);
                check("hold_last", o_tlast, held.l);
            end
            if (o_tvalid && o_tready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    got_b = '{d: o_tdata, c: o_tclip, l: o_tlast};
                    check("sb_data", got_b.d, exp_b.d);
                    check("sb_clip", got_b.c, exp_b.c);
                    check("sb_last", got_b.l, exp_b.l);
                end
                if (CNT_EN != 0 && (|o_tclip) && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            end
            if (CNT_EN != 0 && clear_count) exp_cnt = '0;
            if (i_tvalid && i_tready) sb.push_back(model(i_tdata, round_mode, i_tlast));
            stall_hold = o_tvalid && !o_tready;
            held       = '{d: o_tdata, c: o_tclip, l: o_tlast};
        end
    end

    // Single beat into an empty pipeline with o_tready high; checks 2-edge latency.
    task automatic one_beat(input string tag, input logic [NC*WI-1:0] d, input logic [1:0] m,
                            input logic [NC*WO-1:0] exp_d, input logic [NC-1:0] exp_c,
                            input logic clr);
        i_tdata    = d;
        round_mode = m;
        i_tlast    = 1'b1;
        i_tvalid   = 1'b1;
        o_tready   = 1'b1;
        check({tag, "_ready"}, i_tready, 1);
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        check({tag, "_lat1"}, o_tvalid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, o_tvalid, 1);
        check({tag, "_data"}, o_tdata, exp_d);
        check({tag, "_clip"}, o_tclip, exp_c);
        check({tag, "_last"}, o_tlast, 1);
        clear_count = clr;
        @(posedge clk); #1;
        clear_count = 1'b0;
        check({tag, "_drained"}, o_tvalid, 0);
    endtask

    int   acc;
    int   cyc;
    logic accepted;

    initial begin
        reset       = 1'b1;
        round_mode  = 2'd0;
        clear_count = 1'b0;
        i_tdata     = '0;
        i_tlast     = 1'b0;
        i_tvalid    = 1'b0;
        o_tready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_tvalid, 0);
        check("rst_data", o_tdata, 0);
        check("rst_clip", o_tclip, 0);
        check("rst_last", o_tlast, 0);
        check("rst_cnt", clip_count, 0);
        reset = 1'b0;
        check("rst_ready", i_tready, 1);

        // rounding modes
        one_beat("m1", {24'h000030, 24'h000010}, 2'd1, {16'h0002, 16'h0001}, 2'b00, 1'b0);
        one_beat("m2", {24'h000030, 24'h000010}, 2'd2, {16'h0000, 16'h0002} >> 16 | {16'h0002, 16'h0000}, 2'b00, 1'b0);
        one_beat("m0_neg", {24'h000000, 24'hFFFFF0}, 2'd0, {16'h0000, 16'hFFFF}, 2'b00, 1'b0);
        one_beat("m1_neg", {24'h000000, 24'hFFFFF0}, 2'd1, {16'h0000, 16'h0000}, 2'b00, 1'b0);
        one_beat("m3", {24'h000030, 24'h000010}, 2'd3, {16'h0002, 16'h0001}, 2'b00, 1'b0);
        check("cnt_noclip", clip_count, 0);

        // saturation in every mode; counter steps once per beat
        for (int m = 0; m < 4; m++) begin
            one_beat("clip", CLIPD, 2'(m), {16'h8000, 16'h7FFF}, 2'b11, 1'b0);
            check("clip_cnt", clip_count, CNT_EN * (m + 1));
        end

        // clear coincident with a clipped transfer
        one_beat("clr", CLIPD, 2'd1, {16'h8000, 16'h7FFF}, 2'b11, 1'b1);
        check("clr_cnt", clip_count, 0);

        // randomized stream with random backpressure
        acc = 0;
        cyc = 0;
        i_tdata    = {gen_lane(), gen_lane()};
        round_mode = 2'($urandom_range(0, 3));
        i_tlast    = ($urandom_range(0, 15) == 0);
        while (acc < 1000 && cyc < 20000) begin
            o_tready    = 1'($urandom_range(0, 1));
            clear_count = ($urandom_range(0, 63) == 0);
            if (!i_tvalid) i_tvalid = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            accepted = i_tvalid && i_tready;
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                acc++;
                i_tvalid   = 1'b0;
                i_tdata    = {gen_lane(), gen_lane()};
                round_mode = 2'($urandom_range(0, 3));
                i_tlast    = ($urandom_range(0, 15) == 0);
            end
        end
        check("rand_accepted", acc, 1000);
        i_tvalid    = 1'b0;
        clear_count = 1'b0;
        o_tready    = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("rand_drain", sb.size(), 0);

        // reset with two beats in flight
        o_tready   = 1'b0;
        i_tdata    = CLIPD;
        round_mode = 2'd1;
        i_tvalid   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("inflight_valid", o_tvalid, 1);
        check("inflight_full", i_tready, 0);
        i_tvalid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", o_tvalid, 0);
        check("midrst_data", o_tdata, 0);
        check("midrst_clip", o_tclip, 0);
        check("midrst_cnt", clip_count, 0);
        reset    = 1'b0;
        o_tready = 1'b1;
        check("midrst_ready", i_tready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_stale", o_tvalid, 0);
        end
        one_beat("post_rst", {24'h000030, 24'h000010}, 2'd1, {16'h0002, 16'h0001}, 2'b00, 1'b0);

`ifdef ROUND_CLIP_SAT_COUNT_EN
        // drive the counter into saturation, then confirm it holds
        i_tdata    = CLIPD;
        round_mode = 2'd0;
        i_tvalid   = 1'b1;
        o_tready   = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_sat", clip_count, 16'hFFFF);
        one_beat("sat_hold", CLIPD, 2'd2, {16'h8000, 16'h7FFF}, 2'b11, 1'b0);
        check("cnt_sat_hold", clip_count, 16'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
